// File: rtl/debug_uart_rx.sv
// 8N1 debug-console UART receiver: 2-flop synchronizer, mid-bit sampling,
// single-byte holding register with sticky overrun / framing-error flags.
module debug_uart_rx #(
    parameter int CLK_HZ   = 64_000_000,
    parameter int BIT_RATE = 4_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_overrun,
    output logic       rx_frame_err
);
    localparam int CPB  = CLK_HZ / BIT_RATE;
    localparam int HALF = CPB / 2;
    localparam int TW   = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] T_LAST = TW'(CPB - 1);

    generate
        if (CPB < 4) begin : g_cpb_check
            $error("debug_uart_rx: CLK_HZ/BIT_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_rxd_s;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_busy;
    logic          r_overrun;
    logic          r_ferr;

    logic w_tick;
    logic w_half;

    assign w_tick = (r_timer == T_LAST);
    assign w_half = (r_timer == T_HALF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sync1   <= 1'b1;
            r_rxd_s   <= 1'b1;
            r_timer   <= '0;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync1 <= uart_rxd;
            r_rxd_s <= r_sync1;
            r_timer <= w_tick ? '0 : r_timer + TW'(1);

            // Clears first; any set-event below in the same cycle overrides them.
            if (rx_read) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
                r_ferr    <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (!r_rxd_s) begin
                        r_state <= START;
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_half) begin
                        if (r_rxd_s) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= DATA;
                            r_timer  <= '0;
                            r_bitcnt <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift  <= {r_rxd_s, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    // Leaving mid-stop-bit lets an immediate next start edge be caught.
                    if (w_tick) begin
                        if (r_rxd_s) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            if (!r_valid || rx_read) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (r_rxd_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_busy      = r_busy;
    assign rx_overrun   = r_overrun;
    assign rx_frame_err = r_ferr;

endmodule

// File: tb/tb_debug_uart_rx.sv
// Bench for debug_uart_rx at 16 clocks per bit: drives 8N1 frames and checks
// received bytes against a queue of expected values plus flag/timing checks.
module tb_debug_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       rx_read = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_overrun;
    logic       rx_frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    debug_uart_rx #(
        .CLK_HZ   (64_000_000),
        .BIT_RATE (4_000_000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rxd     (uart_rxd),
        .rx_read      (rx_read),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    // Called on a falling edge; returns on the falling edge after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic pulse_read;
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
        n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", rx_frame_err); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] e;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (2) @(negedge clk);
                n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_t0: got %b want 0", rx_busy); end
                @(negedge clk);
                n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_t1: got %b want 1", rx_busy); end
                repeat (151) @(negedge clk);
                n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_early: got %b want 0", rx_valid); end
                @(negedge clk);
                n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid_t153: got %b want 1", rx_valid); end
                e = exp_q.pop_front();
                n_cmp++; if (rx_data !== e) begin n_bad++; $display("FAIL basic_data: got %h want %h", rx_data, e); end
            end
        join
        pulse_read();
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_read_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL basic_read_data: got %h want a5", rx_data); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [7:0] e;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'h55, 1'b1);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_valid(200, ok);
                    n_cmp++;
                    if (!ok) begin
                        n_bad++; $display("FAIL b2b_timeout: byte %0d valid=%b want 1", k, rx_valid);
                    end else begin
                        e = exp_q.pop_front();
                        if (rx_data !== e) begin n_bad++; $display("FAIL b2b_data: byte %0d got %h want %h", k, rx_data, e); end
                        repeat (2) @(negedge clk);
                        pulse_read();
                    end
                end
            end
        join
        n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b want 0", rx_overrun); end
        n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL b2b_frame_err: got %b want 0", rx_frame_err); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_false_start;
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL fs_busy_start: got %b want 1", rx_busy); end
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL fs_busy_t8: got %b want 1", rx_busy); end
        @(negedge clk);
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL fs_busy_t9: got %b want 0", rx_busy); end
        repeat (40) @(negedge clk);
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL fs_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL fs_frame_err: got %b want 0", rx_frame_err); end
        n_cmp++; if (rx_data !== 8'h55) begin n_bad++; $display("FAIL fs_data: got %h want 55", rx_data); end
    endtask

    task automatic test_frame_err;
        logic [7:0] e;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        n_cmp++; if (rx_frame_err !== 1'b1) begin n_bad++; $display("FAIL fe_flag: got %b want 1", rx_frame_err); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL fe_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL fe_break_busy: got %b want 1", rx_busy); end
        n_cmp++; if (rx_data !== 8'h55) begin n_bad++; $display("FAIL fe_data_kept: got %h want 55", rx_data); end
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL fe_idle: got %b want 0", rx_busy); end
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        e = exp_q.pop_front();
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL fe_next_valid: got %b want 1", rx_valid); end
        n_cmp++; if (rx_data !== e) begin n_bad++; $display("FAIL fe_next_data: got %h want %h", rx_data, e); end
        n_cmp++; if (rx_frame_err !== 1'b1) begin n_bad++; $display("FAIL fe_sticky: got %b want 1", rx_frame_err); end
        pulse_read();
        n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL fe_clear: got %b want 0", rx_frame_err); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL fe_clear_valid: got %b want 0", rx_valid); end
    endtask

    task automatic test_overrun;
        logic [7:0] e;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++; if (rx_data !== e) begin n_bad++; $display("FAIL ovr_data: got %h want %h", rx_data, e); end
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
        n_cmp++; if (rx_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", rx_overrun); end
        pulse_read();
        n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", rx_overrun); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_clear_valid: got %b want 0", rx_valid); end
        // Second pass reads in the accept cycle while the previous byte is still unread.
        for (int k = 0; k < 2; k++) begin
            logic [7:0] b;
            b = (k == 0) ? 8'h33 : 8'h44;
            exp_q.push_back(b);
            fork
                send_frame(b, 1'b1);
                begin
                    repeat (154) @(negedge clk);
                    rx_read = 1'b1;
                    @(negedge clk);
                    rx_read = 1'b0;
                    e = exp_q.pop_front();
                    n_cmp++; if (rx_data !== e) begin n_bad++; $display("FAIL simrd_data: pass %0d got %h want %h", k, rx_data, e); end
                    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL simrd_valid: pass %0d got %b want 1", k, rx_valid); end
                    n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL simrd_overrun: pass %0d got %b want 0", k, rx_overrun); end
                end
            join
        end
        pulse_read();
    endtask

    task automatic test_reset_mid;
        logic [7:0] e;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (85) @(negedge clk);
                n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", rx_busy); end
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
                n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", rx_valid); end
                n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", rx_busy); end
                n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL rstmid_overrun: got %b want 0", rx_overrun); end
                n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_frame_err: got %b want 0", rx_frame_err); end
            end
        join
        repeat (10) @(negedge clk);
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_byte: got %b want 0", rx_valid); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got %b want 0", rx_busy); end
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        e = exp_q.pop_front();
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_next_valid: got %b want 1", rx_valid); end
        n_cmp++; if (rx_data !== e) begin n_bad++; $display("FAIL rstmid_next_data: got %h want %h", rx_data, e); end
        n_cmp++; if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_next_flags: got fe=%b ovr=%b want 0 0", rx_frame_err, rx_overrun);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
